// File: rtl/cosim_trace_pkg.sv
// Shared trace record types and defaults for the cosim trace path.
// Used by the merger and by the cosim checker wrapper.
package cosim_trace_pkg;

  localparam int unsigned DEPTH_DEF = 8;
  localparam int unsigned TAG_W_DEF = 5;
  localparam int unsigned XLEN_DEF  = 64;

  typedef struct packed {
    logic                valid;
    logic [XLEN_DEF-1:0] iaddr;
    logic [31:0]         insn;
    logic                exception;
    logic                interrupt;
    logic [XLEN_DEF-1:0] cause;
    logic                has_wdata;
    logic [XLEN_DEF-1:0] wdata;
    logic [2:0]          priv;
  } trace_rec_t;

endpackage

// File: rtl/cosim_trace_tag_cam.sv
// Tag CAM: compares a writeback tag against every enabled entry.
// Ports: key/lookup in, en/tags per entry in, one-hot hit and none out.
module cosim_trace_tag_cam
  import cosim_trace_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned TAG_W = TAG_W_DEF
) (
  input  logic                           lookup,
  input  logic [TAG_W-1:0]               key,
  input  logic [DEPTH-1:0]               en,
  input  logic [DEPTH-1:0][TAG_W-1:0]    tags,
  output logic [DEPTH-1:0]               hit,
  output logic                           none
);

  always_comb begin
    hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit[i] = lookup & en[i] & (tags[i] == key);
    end
  end

  assign none = ~|hit;

endmodule

// File: rtl/cosim_trace_wb_merger.sv
// Holds commit records until late writeback data arrives, then emits
// them in program order on a compacted two-lane trace bundle.
// Ports: clock/reset, in_0/in_1 commit lanes + in_ready, wb_* late
// writeback, trace_0/trace_1 registered records, occupancy, errors.
module cosim_trace_wb_merger
  import cosim_trace_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned TAG_W = TAG_W_DEF,
  parameter int unsigned XLEN  = XLEN_DEF
) (
  input  logic                    clock,
  input  logic                    reset,

  input  logic                    in_0_valid,
  input  logic [XLEN-1:0]         in_0_iaddr,
  input  logic [31:0]             in_0_insn,
  input  logic                    in_0_exception,
  input  logic                    in_0_interrupt,
  input  logic [XLEN-1:0]         in_0_cause,
  input  logic                    in_0_has_wdata,
  input  logic                    in_0_wdata_pending,
  input  logic [XLEN-1:0]         in_0_wdata,
  input  logic [TAG_W-1:0]        in_0_tag,
  input  logic [2:0]              in_0_priv,

  input  logic                    in_1_valid,
  input  logic [XLEN-1:0]         in_1_iaddr,
  input  logic [31:0]             in_1_insn,
  input  logic                    in_1_exception,
  input  logic                    in_1_interrupt,
  input  logic [XLEN-1:0]         in_1_cause,
  input  logic                    in_1_has_wdata,
  input  logic                    in_1_wdata_pending,
  input  logic [XLEN-1:0]         in_1_wdata,
  input  logic [TAG_W-1:0]        in_1_tag,
  input  logic [2:0]              in_1_priv,

  output logic                    in_ready,

  input  logic                    wb_valid,
  input  logic [TAG_W-1:0]        wb_tag,
  input  logic [XLEN-1:0]         wb_data,

  output logic                    trace_0_valid,
  output logic [XLEN-1:0]         trace_0_iaddr,
  output logic [31:0]             trace_0_insn,
  output logic                    trace_0_exception,
  output logic                    trace_0_interrupt,
  output logic [XLEN-1:0]         trace_0_cause,
  output logic                    trace_0_has_wdata,
  output logic [XLEN-1:0]         trace_0_wdata,
  output logic [2:0]              trace_0_priv,

  output logic                    trace_1_valid,
  output logic [XLEN-1:0]         trace_1_iaddr,
  output logic [31:0]             trace_1_insn,
  output logic                    trace_1_exception,
  output logic                    trace_1_interrupt,
  output logic [XLEN-1:0]         trace_1_cause,
  output logic                    trace_1_has_wdata,
  output logic [XLEN-1:0]         trace_1_wdata,
  output logic [2:0]              trace_1_priv,

  output logic [$clog2(DEPTH):0]  occupancy,
  output logic                    overflow_err,
  output logic                    orphan_wb_err
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;

  // Pointers carry a wrap bit above the index.
  logic [PW-1:0]                  head_q, tail_q;
  logic [DEPTH-1:0]               vld_q, pend_q;
  logic [DEPTH-1:0]               vld_d, pend_d;
  logic [DEPTH-1:0][TAG_W-1:0]    tag_q;
  trace_rec_t                     ent_q [DEPTH];
  trace_rec_t                     tr0_q, tr1_q;

  // Lane bundles
  logic [1:0]                     i_v, i_exc, i_int;
  logic [1:0]                     i_hw, i_wp, i_do;
  logic [1:0][XLEN-1:0]           i_pc, i_cause, i_wd;
  logic [1:0][31:0]               i_insn;
  logic [1:0][TAG_W-1:0]          i_tag;
  logic [1:0][2:0]                i_priv;

  assign i_v     = {in_1_valid, in_0_valid};
  assign i_exc   = {in_1_exception, in_0_exception};
  assign i_int   = {in_1_interrupt, in_0_interrupt};
  assign i_hw    = {in_1_has_wdata, in_0_has_wdata};
  assign i_wp    = {in_1_wdata_pending, in_0_wdata_pending};
  assign i_pc    = {in_1_iaddr, in_0_iaddr};
  assign i_cause = {in_1_cause, in_0_cause};
  assign i_wd    = {in_1_wdata, in_0_wdata};
  assign i_insn  = {in_1_insn, in_0_insn};
  assign i_tag   = {in_1_tag, in_0_tag};
  assign i_priv  = {in_1_priv, in_0_priv};

  assign occupancy = tail_q - head_q;
  assign in_ready  = occupancy <= PW'(DEPTH - 2);
  assign i_do      = {2{in_ready}} & i_v;

  // Enqueue slots: a lone lane-1 record lands at tail.
  logic [IW-1:0] slot0, slot1;
  assign slot0 = tail_q[IW-1:0];
  assign slot1 = tail_q[IW-1:0] + IW'(i_do[0]);

  // Writeback lookup over buffered pending entries.
  logic [DEPTH-1:0] cam_hit;
  logic             cam_none;

  cosim_trace_tag_cam #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_cam (
    .lookup (wb_valid),
    .key    (wb_tag),
    .en     (vld_q & pend_q),
    .tags   (tag_q),
    .hit    (cam_hit),
    .none   (cam_none)
  );

  // Incoming records; a writeback racing its own enqueue resolves here.
  logic [1:0] in_pend, in_wbhit;
  trace_rec_t in_rec [2];

  always_comb begin
    in_pend  = '0;
    in_wbhit = '0;
    for (int l = 0; l < 2; l++) begin
      in_pend[l]  = i_hw[l] & i_wp[l] & ~i_exc[l];
      in_wbhit[l] = i_do[l] & in_pend[l] & wb_valid
                  & (i_tag[l] == wb_tag);
      in_rec[l]           = '0;
      in_rec[l].valid     = 1'b1;
      in_rec[l].iaddr     = i_pc[l];
      in_rec[l].insn      = i_insn[l];
      in_rec[l].exception = i_exc[l];
      in_rec[l].interrupt = i_int[l];
      in_rec[l].cause     = i_cause[l];
      in_rec[l].has_wdata = i_hw[l] & ~i_exc[l];
      in_rec[l].priv      = i_priv[l];
      if (i_hw[l] && !i_exc[l]) begin
        if (!in_pend[l]) begin
          in_rec[l].wdata = i_wd[l];
        end else if (in_wbhit[l]) begin
          in_rec[l].wdata = wb_data;
        end
      end
    end
  end

  // Dequeue: a pending head blocks everything younger.
  logic [IW-1:0] h0, h1;
  logic          emit0, emit1;

  assign h0    = head_q[IW-1:0];
  assign h1    = h0 + IW'(1);
  assign emit0 = vld_q[h0] & ~pend_q[h0];
  assign emit1 = emit0 & vld_q[h1] & ~pend_q[h1];

  always_comb begin
    vld_d  = vld_q;
    pend_d = pend_q & ~cam_hit;
    if (emit0) vld_d[h0] = 1'b0;
    if (emit1) vld_d[h1] = 1'b0;
    if (i_do[0]) begin
      vld_d[slot0]  = 1'b1;
      pend_d[slot0] = in_pend[0] & ~in_wbhit[0];
    end
    if (i_do[1]) begin
      vld_d[slot1]  = 1'b1;
      pend_d[slot1] = in_pend[1] & ~in_wbhit[1];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q        <= '0;
      tail_q        <= '0;
      vld_q         <= '0;
      pend_q        <= '0;
      overflow_err  <= 1'b0;
      orphan_wb_err <= 1'b0;
      tr0_q         <= '0;
      tr1_q         <= '0;
    end else begin
      head_q <= head_q + PW'(emit0) + PW'(emit1);
      tail_q <= tail_q + PW'(i_do[0]) + PW'(i_do[1]);
      vld_q  <= vld_d;
      pend_q <= pend_d;
      if ((|i_v) && !in_ready) overflow_err <= 1'b1;
      if (wb_valid && cam_none && !(|in_wbhit)) begin
        orphan_wb_err <= 1'b1;
      end
      tr0_q <= emit0 ? ent_q[h0] : '0;
      tr1_q <= emit1 ? ent_q[h1] : '0;
    end
  end

  // Payload storage needs no reset; validity lives in vld_q.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (cam_hit[i]) ent_q[i].wdata <= wb_data;
    end
    if (i_do[0]) begin
      ent_q[slot0] <= in_rec[0];
      tag_q[slot0] <= i_tag[0];
    end
    if (i_do[1]) begin
      ent_q[slot1] <= in_rec[1];
      tag_q[slot1] <= i_tag[1];
    end
  end

  assign trace_0_valid     = tr0_q.valid;
  assign trace_0_iaddr     = tr0_q.iaddr;
  assign trace_0_insn      = tr0_q.insn;
  assign trace_0_exception = tr0_q.exception;
  assign trace_0_interrupt = tr0_q.interrupt;
  assign trace_0_cause     = tr0_q.cause;
  assign trace_0_has_wdata = tr0_q.has_wdata;
  assign trace_0_wdata     = tr0_q.wdata;
  assign trace_0_priv      = tr0_q.priv;

  assign trace_1_valid     = tr1_q.valid;
  assign trace_1_iaddr     = tr1_q.iaddr;
  assign trace_1_insn      = tr1_q.insn;
  assign trace_1_exception = tr1_q.exception;
  assign trace_1_interrupt = tr1_q.interrupt;
  assign trace_1_cause     = tr1_q.cause;
  assign trace_1_has_wdata = tr1_q.has_wdata;
  assign trace_1_wdata     = tr1_q.wdata;
  assign trace_1_priv      = tr1_q.priv;

endmodule

// File: tb/tb_cosim_trace_wb_merger.sv
// Bench for cosim_trace_wb_merger: directed steps, then a random
// stream checked against an in-order expected-record queue.
module tb_cosim_trace_wb_merger;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic        in_0_valid, in_0_exception, in_0_interrupt;
  logic        in_0_has_wdata, in_0_wdata_pending;
  logic [63:0] in_0_iaddr, in_0_cause, in_0_wdata;
  logic [31:0] in_0_insn;
  logic [4:0]  in_0_tag;
  logic [2:0]  in_0_priv;
  logic        in_1_valid, in_1_exception, in_1_interrupt;
  logic        in_1_has_wdata, in_1_wdata_pending;
  logic [63:0] in_1_iaddr, in_1_cause, in_1_wdata;
  logic [31:0] in_1_insn;
  logic [4:0]  in_1_tag;
  logic [2:0]  in_1_priv;
  logic        in_ready;
  logic        wb_valid;
  logic [4:0]  wb_tag;
  logic [63:0] wb_data;
  logic        trace_0_valid, trace_0_exception, trace_0_interrupt;
  logic        trace_0_has_wdata;
  logic [63:0] trace_0_iaddr, trace_0_cause, trace_0_wdata;
  logic [31:0] trace_0_insn;
  logic [2:0]  trace_0_priv;
  logic        trace_1_valid, trace_1_exception, trace_1_interrupt;
  logic        trace_1_has_wdata;
  logic [63:0] trace_1_iaddr, trace_1_cause, trace_1_wdata;
  logic [31:0] trace_1_insn;
  logic [2:0]  trace_1_priv;
  logic [3:0]  occupancy;
  logic        overflow_err, orphan_wb_err;

  cosim_trace_wb_merger dut (
    .clock(clock), .reset(reset),
    .in_0_valid(in_0_valid), .in_0_iaddr(in_0_iaddr),
    .in_0_insn(in_0_insn), .in_0_exception(in_0_exception),
    .in_0_interrupt(in_0_interrupt), .in_0_cause(in_0_cause),
    .in_0_has_wdata(in_0_has_wdata),
    .in_0_wdata_pending(in_0_wdata_pending),
    .in_0_wdata(in_0_wdata), .in_0_tag(in_0_tag),
    .in_0_priv(in_0_priv),
    .in_1_valid(in_1_valid), .in_1_iaddr(in_1_iaddr),
    .in_1_insn(in_1_insn), .in_1_exception(in_1_exception),
    .in_1_interrupt(in_1_interrupt), .in_1_cause(in_1_cause),
    .in_1_has_wdata(in_1_has_wdata),
    .in_1_wdata_pending(in_1_wdata_pending),
    .in_1_wdata(in_1_wdata), .in_1_tag(in_1_tag),
    .in_1_priv(in_1_priv),
    .in_ready(in_ready),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .trace_0_valid(trace_0_valid), .trace_0_iaddr(trace_0_iaddr),
    .trace_0_insn(trace_0_insn),
    .trace_0_exception(trace_0_exception),
    .trace_0_interrupt(trace_0_interrupt),
    .trace_0_cause(trace_0_cause),
    .trace_0_has_wdata(trace_0_has_wdata),
    .trace_0_wdata(trace_0_wdata), .trace_0_priv(trace_0_priv),
    .trace_1_valid(trace_1_valid), .trace_1_iaddr(trace_1_iaddr),
    .trace_1_insn(trace_1_insn),
    .trace_1_exception(trace_1_exception),
    .trace_1_interrupt(trace_1_interrupt),
    .trace_1_cause(trace_1_cause),
    .trace_1_has_wdata(trace_1_has_wdata),
    .trace_1_wdata(trace_1_wdata), .trace_1_priv(trace_1_priv),
    .occupancy(occupancy),
    .overflow_err(overflow_err), .orphan_wb_err(orphan_wb_err)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] insn;
    logic        exc, intr;
    logic [63:0] cause;
    logic        hw, wp;
    logic [63:0] wd;
    logic [4:0]  tag;
    logic [2:0]  priv;
    logic [63:0] wbd;
  } brec_t;

  typedef struct {
    logic [4:0]  tag;
    logic [63:0] data;
    int          due;
  } wbi_t;

  int checks = 0;
  int failures = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    in_0_valid = 0; in_0_iaddr = 0; in_0_insn = 0;
    in_0_exception = 0; in_0_interrupt = 0; in_0_cause = 0;
    in_0_has_wdata = 0; in_0_wdata_pending = 0; in_0_wdata = 0;
    in_0_tag = 0; in_0_priv = 0;
    in_1_valid = 0; in_1_iaddr = 0; in_1_insn = 0;
    in_1_exception = 0; in_1_interrupt = 0; in_1_cause = 0;
    in_1_has_wdata = 0; in_1_wdata_pending = 0; in_1_wdata = 0;
    in_1_tag = 0; in_1_priv = 0;
    wb_valid = 0; wb_tag = 0; wb_data = 0;
  endtask

  task automatic drive(int n, brec_t r);
    if (n == 0) begin
      in_0_valid = 1; in_0_iaddr = r.pc; in_0_insn = r.insn;
      in_0_exception = r.exc; in_0_interrupt = r.intr;
      in_0_cause = r.cause; in_0_has_wdata = r.hw;
      in_0_wdata_pending = r.wp; in_0_wdata = r.wd;
      in_0_tag = r.tag; in_0_priv = r.priv;
    end else begin
      in_1_valid = 1; in_1_iaddr = r.pc; in_1_insn = r.insn;
      in_1_exception = r.exc; in_1_interrupt = r.intr;
      in_1_cause = r.cause; in_1_has_wdata = r.hw;
      in_1_wdata_pending = r.wp; in_1_wdata = r.wd;
      in_1_tag = r.tag; in_1_priv = r.priv;
    end
  endtask

  function automatic brec_t mkrec(logic [63:0] pc, logic [31:0] insn,
                                  logic hw, logic wp, logic [63:0] wd,
                                  logic [4:0] tag);
    brec_t r;
    r.pc = pc; r.insn = insn; r.exc = 0; r.intr = 0; r.cause = 0;
    r.hw = hw; r.wp = wp; r.wd = wd; r.tag = tag; r.priv = 3'd3;
    r.wbd = 0;
    return r;
  endfunction

  function automatic brec_t rnd_rec();
    brec_t r;
    r.pc    = {$urandom, $urandom};
    r.insn  = $urandom;
    r.exc   = ($urandom_range(0, 9) == 0);
    r.intr  = r.exc & 1'($urandom_range(0, 1));
    r.cause = r.exc ? 64'($urandom_range(0, 15)) : 64'd0;
    r.hw    = ($urandom_range(0, 9) < 7);
    r.wp    = 1'($urandom_range(0, 1));
    r.wd    = {$urandom, $urandom};
    r.tag   = 0;
    r.priv  = 3'($urandom_range(0, 7));
    r.wbd   = {$urandom, $urandom};
    return r;
  endfunction

  // What the checker must see for a record: traps drop wdata, and a
  // late record carries the data of its eventual writeback.
  function automatic logic [63:0] exp_wd(brec_t r);
    if (!r.hw || r.exc) return 64'd0;
    if (r.wp) return r.wbd;
    return r.wd;
  endfunction

  brec_t exp_q[$];
  bit    sb_on = 0;
  int    n_in = 0;
  int    n_out = 0;

  task automatic check_lane(string ln, logic v, logic [63:0] pc,
                            logic [31:0] insn, logic exc, logic intr,
                            logic [63:0] cause, logic hw,
                            logic [63:0] wd, logic [2:0] pr);
    brec_t e;
    if (!v) begin
      chk({ln, "_idle_zero"},
          64'(|{pc, insn, exc, intr, cause, hw, wd, pr}), 64'd0);
      return;
    end
    chk({ln, "_rec_available"}, 64'(exp_q.size() > 0), 64'd1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    n_out++;
    chk({ln, "_iaddr"}, pc, e.pc);
    chk({ln, "_insn"}, 64'(insn), 64'(e.insn));
    chk({ln, "_cause"}, cause, e.cause);
    chk({ln, "_flags"}, 64'({exc, intr, hw, pr}),
        64'({e.exc, e.intr, e.hw & ~e.exc, e.priv}));
    chk({ln, "_wdata"}, wd, exp_wd(e));
  endtask

  always @(negedge clock) begin
    if (sb_on) begin
      chk("lane_compact", 64'(trace_1_valid & ~trace_0_valid), 64'd0);
      check_lane("t0", trace_0_valid, trace_0_iaddr, trace_0_insn,
                 trace_0_exception, trace_0_interrupt, trace_0_cause,
                 trace_0_has_wdata, trace_0_wdata, trace_0_priv);
      check_lane("t1", trace_1_valid, trace_1_iaddr, trace_1_insn,
                 trace_1_exception, trace_1_interrupt, trace_1_cause,
                 trace_1_has_wdata, trace_1_wdata, trace_1_priv);
    end
  end

  brec_t     r;
  wbi_t      outs[$];
  bit        tag_busy [32];
  logic [4:0] t;
  int        d, sel, sent, cyc, wait_n;
  bit        wb_set;

  initial begin
    idle();
    foreach (tag_busy[i]) tag_busy[i] = 0;

    // Reset
    tick(); tick();
    chk("rst_t0_valid", trace_0_valid, 0);
    chk("rst_t1_valid", trace_1_valid, 0);
    chk("rst_t0_iaddr", trace_0_iaddr, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_errs", {overflow_err, orphan_wb_err}, 0);
    reset = 1;
    tick();
    chk("rdy_after_rst", in_ready, 1);

    // Single non-pending record
    drive(0, mkrec(64'h8000_0000, 32'h0000_0013, 0, 0, 0, 0));
    tick();
    idle();
    chk("t1_lat_t0_valid", trace_0_valid, 0);
    chk("t1_occ1", occupancy, 1);
    tick();
    chk("t1_t0_valid", trace_0_valid, 1);
    chk("t1_t0_iaddr", trace_0_iaddr, 64'h8000_0000);
    chk("t1_t0_insn", trace_0_insn, 32'h13);
    chk("t1_t0_priv", trace_0_priv, 3);
    chk("t1_t1_valid", trace_1_valid, 0);
    chk("t1_occ0", occupancy, 0);

    // Pending load blocks younger ALU op until writeback
    drive(0, mkrec(64'h8000_0004, 32'h0000_3083, 1, 1, 0, 5'd3));
    drive(1, mkrec(64'h8000_0008, 32'h0010_8113, 1, 0, 64'h55, 0));
    tick();
    idle();
    chk("t2_occ2", occupancy, 2);
    tick();
    chk("t2_blocked", {trace_0_valid, trace_1_valid}, 0);
    wb_valid = 1; wb_tag = 3; wb_data = 64'hDEAD;
    tick();
    idle();
    chk("t2_wb_edge", trace_0_valid, 0);
    tick();
    chk("t2_t0_valid", trace_0_valid, 1);
    chk("t2_t0_iaddr", trace_0_iaddr, 64'h8000_0004);
    chk("t2_t0_wdata", trace_0_wdata, 64'hDEAD);
    chk("t2_t0_hw", trace_0_has_wdata, 1);
    chk("t2_t1_valid", trace_1_valid, 1);
    chk("t2_t1_iaddr", trace_1_iaddr, 64'h8000_0008);
    chk("t2_t1_wdata", trace_1_wdata, 64'h55);
    chk("t2_orphan", orphan_wb_err, 0);

    // Lone lane-1 record compacts onto lane 0
    drive(1, mkrec(64'h8000_0100, 32'h0000_0033, 0, 0, 0, 0));
    tick();
    idle();
    tick();
    chk("t3_t0_valid", trace_0_valid, 1);
    chk("t3_t0_iaddr", trace_0_iaddr, 64'h8000_0100);
    chk("t3_t1_valid", trace_1_valid, 0);
    chk("t3_t1_iaddr", trace_1_iaddr, 0);

    // Trap with insn 0 and a pending flag: never pending, no wdata
    r = mkrec(64'h8000_0200, 32'h0, 1, 1, 64'h77, 5'd11);
    r.exc = 1; r.cause = 64'd5;
    drive(0, r);
    tick();
    idle();
    tick();
    chk("t3b_valid", trace_0_valid, 1);
    chk("t3b_exc", trace_0_exception, 1);
    chk("t3b_cause", trace_0_cause, 5);
    chk("t3b_hw", trace_0_has_wdata, 0);
    chk("t3b_wdata", trace_0_wdata, 0);

    // Fill to DEPTH-1 behind a pending head, then overflow
    drive(0, mkrec(64'h9000_0000, 32'h1, 1, 1, 0, 5'd9));
    tick();
    for (int i = 0; i < 3; i++) begin
      idle();
      drive(0, mkrec(64'h9000_0010 + 64'(i * 8), 32'h2, 0, 0, 0, 0));
      drive(1, mkrec(64'h9000_0014 + 64'(i * 8), 32'h3, 0, 0, 0, 0));
      tick();
    end
    idle();
    chk("t4_occ7", occupancy, 7);
    chk("t4_not_ready", in_ready, 0);
    chk("t4_no_ovf_yet", overflow_err, 0);
    drive(0, mkrec(64'hBAD0_0000, 32'h4, 0, 0, 0, 0));
    tick();
    idle();
    chk("t4_ovf", overflow_err, 1);
    chk("t4_occ_kept", occupancy, 7);

    // Orphan writeback leaves the buffer alone
    wb_valid = 1; wb_tag = 7; wb_data = 64'h1111;
    tick();
    idle();
    chk("t5_orphan", orphan_wb_err, 1);
    chk("t5_occ", occupancy, 7);
    tick();
    chk("t5_still_blocked", trace_0_valid, 0);

    // Release the head and drain
    wb_valid = 1; wb_tag = 9; wb_data = 64'h1234;
    tick();
    idle();
    tick();
    chk("t5_head_iaddr", trace_0_iaddr, 64'h9000_0000);
    chk("t5_head_wdata", trace_0_wdata, 64'h1234);
    chk("t5_t1_iaddr", trace_1_iaddr, 64'h9000_0010);
    chk("t5_occ5", occupancy, 5);
    tick(); tick(); tick();
    chk("t5_last_iaddr", trace_0_iaddr, 64'h9000_0024);
    chk("t5_drained", occupancy, 0);

    // Mid-operation reset discards and clears sticky flags
    drive(0, mkrec(64'hA000_0000, 32'h5, 1, 1, 0, 5'd1));
    tick();
    idle();
    reset = 0;
    #2;
    chk("mid_rst_occ", occupancy, 0);
    chk("mid_rst_errs", {overflow_err, orphan_wb_err}, 0);
    tick();
    reset = 1;
    tick();

    // Random stream
    sb_on = 1;
    sent = 0;
    cyc = 0;
    while ((sent < 100 || outs.size() > 0) && cyc < 4000) begin
      idle();
      wb_set = 0;
      if (sent < 100 && in_ready && $urandom_range(0, 3) != 0) begin
        sel = $urandom_range(0, 2);
        for (int l = 0; l < 2; l++) begin
          if ((l == 0 && sel != 1) || (l == 1 && sel != 0)) begin
            r = rnd_rec();
            if (r.hw && r.wp && !r.exc) begin
              do t = 5'($urandom_range(0, 31)); while (tag_busy[t]);
              chk("tag_unique", 64'(tag_busy[t]), 0);
              tag_busy[t] = 1;
              r.tag = t;
              d = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(0, 20);
              if (d == 0 && !wb_set) begin
                wb_valid = 1; wb_tag = t; wb_data = r.wbd;
                wb_set = 1;
              end else begin
                outs.push_back('{t, r.wbd, cyc + d});
              end
            end else begin
              r.tag = 5'($urandom_range(0, 31));
            end
            exp_q.push_back(r);
            n_in++;
            drive(l, r);
          end
        end
        sent++;
      end
      if (!wb_set) begin
        for (int i = 0; i < outs.size(); i++) begin
          if (outs[i].due <= cyc) begin
            wb_valid = 1; wb_tag = outs[i].tag; wb_data = outs[i].data;
            wb_set = 1;
            outs.delete(i);
            break;
          end
        end
      end
      tick();
      if (wb_set) tag_busy[wb_tag] = 0;
      cyc++;
    end
    idle();
    chk("stream_done", 64'(outs.size()), 0);
    wait_n = 0;
    while (exp_q.size() > 0 && wait_n < 200) begin
      tick();
      wait_n++;
    end
    tick();
    sb_on = 0;
    chk("drain_q_empty", 64'(exp_q.size()), 0);
    chk("drain_count", 64'(n_out), 64'(n_in));
    chk("rnd_occ0", occupancy, 0);
    chk("rnd_no_ovf", overflow_err, 0);
    chk("rnd_no_orphan", orphan_wb_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
